// File: rtl/rgb_fade_pkg.sv
// rgb_fade_pkg: shared mode encodings, ramp states and channel indices for the RGB fade engine
package rgb_fade_pkg;
  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_STATIC = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_CYCLE = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} fade_state_t;
  localparam int CH_RED = 0;
  localparam int CH_GREEN = 1;
  localparam int CH_BLUE = 2;
endpackage

// File: rtl/rgb_fade_engine_pwm_channel.sv
// pwm_channel: registered compare of the shared PWM counter against one channel's duty
module pwm_channel #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 hw_clk,
  input  logic                 rst,
  input  logic [PWM_WIDTH-1:0] cnt,
  input  logic [PWM_WIDTH-1:0] duty,
  output logic                 pwm
);
  always_ff @(posedge hw_clk) pwm <= rst ? 1'b0 : cnt < duty;
endmodule

// File: rtl/rgb_fade_engine.sv
// rgb_fade_engine: prescaled brightness ramp FSM and per-channel PWM enables for the RGB LED
module rgb_fade_engine
  import rgb_fade_pkg::*;
#(
  parameter int PWM_WIDTH = 8,
  parameter int NUM_CH = 3,
  parameter int TICK_DIV = 2097152,
  parameter int STEP = 32,
  localparam int AW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                 hw_clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [PWM_WIDTH-1:0] static_level,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic [PWM_WIDTH-1:0] level_out,
  output logic [AW-1:0]        active_ch,
  output logic                 cycle_done
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [PWM_WIDTH-1:0] MAX = '1;
  localparam logic [PWM_WIDTH:0] MAX_X = {1'b0, MAX};
  localparam logic [PWM_WIDTH:0] STEP_X = (PWM_WIDTH + 1)'(STEP);
  logic [PW-1:0] presc;
  logic [PWM_WIDTH-1:0] pwm_cnt, lvl_up, lvl_dn;
  logic [PWM_WIDTH:0] sum;
  logic [1:0] mode_q;
  logic tick, mode_chg;
  fade_state_t state;
  always_comb begin
    tick = presc == PRE_TOP;
    mode_chg = mode != mode_q;
    sum = {1'b0, level_out} + STEP_X;
    lvl_up = sum > MAX_X ? MAX : sum[PWM_WIDTH-1:0];
    lvl_dn = {1'b0, level_out} > STEP_X ? level_out - STEP_X[PWM_WIDTH-1:0] : '0;
  end
  // a mode change outranks a coincident tick, so the ramp always restarts cleanly from 0
  always_ff @(posedge hw_clk) begin
    mode_q <= mode;
    if (rst) begin
      presc <= '0;
      pwm_cnt <= '0;
      level_out <= '0;
      active_ch <= '0;
      cycle_done <= 1'b0;
      state <= ST_IDLE;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      cycle_done <= 1'b0;
      if (mode_chg) begin
        level_out <= '0;
        active_ch <= '0;
        state <= ST_IDLE;
      end else if (!mode[1]) begin
        level_out <= '0;
        state <= ST_IDLE;
      end else if (state == ST_IDLE) begin
        state <= ST_UP;
      end else if (tick && state == ST_UP) begin
        level_out <= lvl_up;
        if (lvl_up == MAX) state <= ST_DOWN;
      end else if (tick) begin
        level_out <= lvl_dn;
        if (lvl_dn == '0) begin
          cycle_done <= 1'b1;
          state <= ST_UP;
          if (mode == MODE_CYCLE) active_ch <= active_ch == AW'(NUM_CH - 1) ? '0 : active_ch + 1'b1;
        end
      end
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PWM_WIDTH-1:0] duty;
    always_comb duty = mode == MODE_STATIC ? (ch_en[i] ? static_level : '0) :
                       mode == MODE_BREATHE ? (ch_en[i] ? level_out : '0) :
                       mode == MODE_CYCLE ? (active_ch == AW'(i) ? level_out : '0) : '0;
    pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_pwm (
      .hw_clk(hw_clk),
      .rst(rst),
      .cnt(pwm_cnt),
      .duty(duty),
      .pwm(pwm_out[i])
    );
  end
endmodule
